cpri_pattern_play_ctrl: RTL and testbench
=========================================

# cpri_pattern_play_ctrl

Playback scheduler for the CPRI test-pattern path. It generates the read address and read enable for the bank of eight 64-bit pattern ROMs. It sequences symbols within a configurable frame and gates reads per symbol with a mask. It emits chip-aligned SOP plus data-valid and symbol-boundary strobes delayed to match ROM read latency, so the downstream CPRI combiner receives words with aligned qualifiers.

## Interface
- CHIP_LEN, 96: words per CPRI chip; free-running chip counter wraps at CHIP_LEN-1.
- SOP_OFS, 3: chip_cnt value at which sop_o is asserted.
- ADDR_W, 16: ROM address width.
- SYM_W, 3: width of symbol index and period.
- RD_LAT, 2: ROM read latency plus output register, in cycles.
- clk  in  1  single clock.
- rst  in  1  reset, synchronous and active-high.
- start_i  in  1  pulse; arm playback and latch the cfg_* inputs.
- stop_i  in  1  pulse; finish the current symbol, then return to idle.
- cfg_len_i  in  ADDR_W  words per symbol, for example 44352.
- cfg_sym_period_i  in  SYM_W  symbols per frame, for example 5.
- cfg_sym_mask_i  in  2**SYM_W  bit n set means symbol n reads the ROM.
- rom_addr_o  out  ADDR_W  ROM address; 0 when rom_rden_o=0.
- rom_rden_o  out  1  ROM read enable.
- dat_vld_o  out  1  rom_rden_o delayed by RD_LAT.
- sym_sop_o  out  1  first word of an active symbol, delayed by RD_LAT.
- sym_eop_o  out  1  last word of an active symbol, delayed by RD_LAT.
- sym_idx_o  out  SYM_W  symbol index, delayed by RD_LAT.
- sop_o  out  1  chip SOP, asserted when chip_cnt==SOP_OFS.
- busy_o  out  1  asserted when state is not IDLE.

## Operation
- States:
  - IDLE: waiting for start.
  - ARM: waiting for a chip boundary.
  - RUN: normal playback.
  - DRAIN: stop requested; finish the current symbol.
- Transitions:
  - IDLE→ARM on start_i, provided latched cfg_len≠0 and cfg_sym_period≠0. Otherwise start is ignored.
  - ARM→RUN on the cycle after chip_cnt==CHIP_LEN-1.
  - RUN→DRAIN on stop_i.
  - DRAIN→IDLE when addr_cnt==len-1 has been issued.
  - stop_i in ARM forces IDLE.
- Priority and ignored inputs:
  - start_i outside IDLE is ignored.
  - start_i and stop_i together in IDLE: stop wins; remain in IDLE.
- Counters:
  - addr_cnt runs 0..len-1 and wraps to 0.
  - On each wrap, sym_cnt increments and wraps at period-1.
  - addr_cnt advances in every RUN/DRAIN cycle, including masked symbols. This keeps symbol timing identical whatever the mask.
- Read gating:
  - rom_rden_o = (RUN or DRAIN) and mask[sym_cnt].
  - rom_addr_o = addr_cnt when rden is asserted, else 0.
- Boundary strobes:
  - sym_sop is generated at addr_cnt==0 and sym_eop at addr_cnt==len-1, both gated by rden.
  - If len==1, both are asserted on the same word.
- Configuration is latched on the accepted start only. Changes to cfg_* during RUN are ignored.
- chip_cnt is free-running from reset and is independent of the state machine.

## Timing
- Reset values:
  - state=IDLE; chip_cnt, addr_cnt and sym_cnt are 0.
  - rom_addr_o, rom_rden_o, dat_vld_o, sym_sop_o, sym_eop_o, sym_idx_o and busy_o are all 0.
  - The delay pipeline is cleared.
- sop_o first asserts 3 cycles after rst deasserts (chip_cnt 0,1,2,3), then every CHIP_LEN cycles.
- rom_addr_o and rom_rden_o are registered. The first RUN cycle presents addr 0.
- dat_vld_o, sym_sop_o, sym_eop_o and sym_idx_o lag rom_rden_o by exactly RD_LAT cycles.
- Reset mid-operation clears everything within 1 cycle; no delayed strobes appear after reset.
- On stop in DRAIN, delayed strobes for already-issued reads still emerge. busy_o drops when the state returns to IDLE, not when the pipeline empties.

## Structure
- Package cpri_play_pkg holds:
  - the state enum (IDLE, ARM, RUN, DRAIN);
  - default constants CHIP_LEN=96, SOP_OFS=3 and RD_LAT=2;
  - the default symbol length 44352.
- Sub-module cpri_play_dly: a parameterised RD_LAT-deep shift register with synchronous clear, used for {rden, sym_sop, sym_eop, sym_idx}.

## Test plan
- Basic playback: cfg_len=4, period=3, mask=3'b001, start → rom_addr_o 0,1,2,3 with rden=1, then 8 cycles of rden=0, repeating. dat_vld_o follows 2 cycles later, with sym_sop on addr 0 and sym_eop on addr 3.
- Chip alignment: start asserted at chip_cnt=10 → first rden in the cycle after chip_cnt=95. sop_o is asserted at every chip_cnt=3.
- Stop handling: stop_i at addr_cnt=1 of an active symbol with len=4 → addrs 2,3 are still issued, then IDLE. The last dat_vld_o occurs 2 cycles after addr 3.
- Illegal start and priority: start with cfg_len=0 → busy_o stays 0. Start and stop in the same cycle → remains in IDLE.
- Mask and single-word symbol: mask=3'b101, period=3, len=1 → rden on symbols 0 and 2 only, with sym_sop and sym_eop asserted together and sym_idx_o = 0, then 2.
- Reset mid-RUN: rst at addr 2 → next cycle all outputs are 0 and no stale dat_vld_o is emitted. sop_o resumes 3 cycles after rst release.

Source files
------------

// File: rtl/cpri_play_pkg.sv
// Shared types and default constants for the CPRI test-pattern playback scheduler.
package cpri_play_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDrain
  } play_state_e;

  localparam int unsigned DEF_CHIP_LEN = 96;
  localparam int unsigned DEF_SOP_OFS  = 3;
  localparam int unsigned DEF_RD_LAT   = 2;
  localparam int unsigned DEF_SYM_LEN  = 44352;
  // Address width needed to reach every word of a default-length symbol.
  localparam int unsigned DEF_ADDR_W   = $clog2(DEF_SYM_LEN + 1);

endpackage

// File: rtl/cpri_play_dly.sv
// Fixed-depth shift register with synchronous clear; aligns qualifiers with ROM read latency.
module cpri_play_dly #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/cpri_pattern_play_ctrl.sv
// Playback scheduler: chip-aligned start, per-symbol ROM read gating and latency-matched strobes.
module cpri_pattern_play_ctrl
  import cpri_play_pkg::*;
#(
  parameter int unsigned CHIP_LEN = DEF_CHIP_LEN,
  parameter int unsigned SOP_OFS  = DEF_SOP_OFS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned SYM_W    = 3,
  parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [ADDR_W-1:0]     cfg_len_i,
  input  logic [SYM_W-1:0]      cfg_sym_period_i,
  input  logic [2**SYM_W-1:0]   cfg_sym_mask_i,
  output logic [ADDR_W-1:0]     rom_addr_o,
  output logic                  rom_rden_o,
  output logic                  dat_vld_o,
  output logic                  sym_sop_o,
  output logic                  sym_eop_o,
  output logic [SYM_W-1:0]      sym_idx_o,
  output logic                  sop_o,
  output logic                  busy_o
);

  localparam int unsigned ChipW = $clog2(CHIP_LEN);
  localparam logic [ChipW-1:0] ChipLast = ChipW'(CHIP_LEN - 1);
  localparam logic [ChipW-1:0] SopAt    = ChipW'(SOP_OFS);

  logic [ChipW-1:0]     chip_cnt_q;
  play_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d, len_q;
  logic [SYM_W-1:0]     sym_q, sym_d, period_q;
  logic [2**SYM_W-1:0]  mask_q;
  logic                 start_ok, last_word, last_sym;
  logic                 rden_d, ssop_d, seop_d;
  logic [ADDR_W-1:0]    rom_addr_d;
  logic [SYM_W-1:0]     idx_d;
  logic                 sym_sop_q, sym_eop_q;
  logic [SYM_W-1:0]     sym_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chip_cnt_q <= '0;
    end else begin
      chip_cnt_q <= (chip_cnt_q == ChipLast) ? '0 : chip_cnt_q + ChipW'(1);
    end
  end

  assign sop_o  = (chip_cnt_q == SopAt);
  assign busy_o = (state_q != StIdle);

  // Stop beats start when both arrive in idle; a zero length or period is never armed.
  assign start_ok = (state_q == StIdle) && start_i && !stop_i &&
                    (cfg_len_i != '0) && (cfg_sym_period_i != '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sym_d     = sym_q;
    last_word = (addr_q == len_q - ADDR_W'(1));
    last_sym  = (sym_q == period_q - SYM_W'(1));

    unique case (state_q)
      StIdle:  if (start_ok) state_d = StArm;
      StArm: begin
        if (stop_i) state_d = StIdle;
        else if (chip_cnt_q == ChipLast) state_d = StRun;
      end
      StRun:   if (stop_i) state_d = last_word ? StIdle : StDrain;
      StDrain: if (last_word) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Counters advance even through masked symbols so frame timing is mask-independent.
    if (state_q inside {StRun, StDrain}) begin
      addr_d = last_word ? '0 : addr_q + ADDR_W'(1);
      if (last_word) sym_d = last_sym ? '0 : sym_q + SYM_W'(1);
    end
    if (state_d == StIdle) begin
      addr_d = '0;
      sym_d  = '0;
    end

    rden_d     = (state_d inside {StRun, StDrain}) && mask_q[sym_d];
    rom_addr_d = rden_d ? addr_d : '0;
    ssop_d     = rden_d && (addr_d == '0);
    seop_d     = rden_d && (addr_d == len_q - ADDR_W'(1));
    idx_d      = rden_d ? sym_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      sym_q      <= '0;
      len_q      <= '0;
      period_q   <= '0;
      mask_q     <= '0;
      rom_rden_o <= 1'b0;
      rom_addr_o <= '0;
      sym_sop_q  <= 1'b0;
      sym_eop_q  <= 1'b0;
      sym_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sym_q      <= sym_d;
      rom_rden_o <= rden_d;
      rom_addr_o <= rom_addr_d;
      sym_sop_q  <= ssop_d;
      sym_eop_q  <= seop_d;
      sym_idx_q  <= idx_d;
      if (start_ok) begin
        len_q    <= cfg_len_i;
        period_q <= cfg_sym_period_i;
        mask_q   <= cfg_sym_mask_i;
      end
    end
  end

  cpri_play_dly #(
    .Width (3 + SYM_W),
    .Depth (RD_LAT)
  ) u_dly (
    .clk (clk),
    .clr (rst),
    .d_i ({rom_rden_o, sym_sop_q, sym_eop_q, sym_idx_q}),
    .q_o ({dat_vld_o, sym_sop_o, sym_eop_o, sym_idx_o})
  );

endmodule

// File: tb/tb_cpri_pattern_play_ctrl.sv
// Self-checking bench: scenario table, hand-written corner sequences and a randomized run
// compared every cycle against a schedule-arithmetic reference model.
module tb_cpri_pattern_play_ctrl;

  localparam int ChipLen = 96;
  localparam int SopOfs  = 3;
  localparam int RdLat   = 2;
  localparam int Never   = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst, start_i, stop_i;
  logic [15:0] cfg_len_i;
  logic [2:0]  cfg_sym_period_i;
  logic [7:0]  cfg_sym_mask_i;
  logic [15:0] rom_addr_o;
  logic        rom_rden_o, dat_vld_o, sym_sop_o, sym_eop_o, sop_o, busy_o;
  logic [2:0]  sym_idx_o;

  cpri_pattern_play_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .cfg_len_i        (cfg_len_i),
    .cfg_sym_period_i (cfg_sym_period_i),
    .cfg_sym_mask_i   (cfg_sym_mask_i),
    .rom_addr_o       (rom_addr_o),
    .rom_rden_o       (rom_rden_o),
    .dat_vld_o        (dat_vld_o),
    .sym_sop_o        (sym_sop_o),
    .sym_eop_o        (sym_eop_o),
    .sym_idx_o        (sym_idx_o),
    .sop_o            (sop_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rden;
    logic       ssop;
    logic       seop;
    logic [2:0] idx;
  } pre_t;

  typedef struct {
    int         len;
    int         per;
    logic [7:0] mask;
    int         stop_ofs;
    int         e_rden;
    int         e_ssop;
    int         e_seop;
    int         e_busy;
  } scn_t;

  int checks = 0;
  int errors = 0;

  // Reference model: playback is a pure function of the run-start cycle and the stop cycle.
  pre_t       hist [int];
  int         n = 0;
  int         n_rel = 0;
  int         clr_from = 0;
  int         run_cyc = 0;
  int         end_cyc = 0;
  bit         m_busy = 1'b0;
  bit         m_stopped = 1'b0;
  int         m_len = 1;
  int         m_per = 1;
  logic [7:0] m_mask = '0;

  function automatic int chip_of(int c);
    return (c - n_rel) % ChipLen;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_busy   = 1'b0;
      n_rel    = n + 1;
      clr_from = n + 1;
    end else if (!m_busy) begin
      if (start_i && !stop_i && cfg_len_i != 0 && cfg_sym_period_i != 0) begin
        m_busy    = 1'b1;
        m_stopped = 1'b0;
        m_len     = int'(cfg_len_i);
        m_per     = int'(cfg_sym_period_i);
        m_mask    = cfg_sym_mask_i;
        run_cyc   = n + 2 + (ChipLen - 1 - chip_of(n + 1));
        end_cyc   = Never;
      end
    end else if (stop_i && !m_stopped) begin
      m_stopped = 1'b1;
      if (n < run_cyc) end_cyc = n;
      else end_cyc = run_cyc + ((n - run_cyc) / m_len + 1) * m_len - 1;
    end
  endtask

  task automatic model_check();
    pre_t        p, d;
    int          k, addr, sym;
    logic [24:0] exp_v, act_v;
    if (m_busy && n > end_cyc) m_busy = 1'b0;
    p = '0;
    addr = 0;
    if (m_busy && n >= run_cyc) begin
      k      = n - run_cyc;
      addr   = k % m_len;
      sym    = (k / m_len) % m_per;
      p.rden = m_mask[sym];
      p.ssop = p.rden && addr == 0;
      p.seop = p.rden && addr == m_len - 1;
      p.idx  = p.rden ? sym[2:0] : 3'd0;
    end
    hist[n] = p;
    d = (n - RdLat >= clr_from) ? hist[n - RdLat] : '0;
    exp_v = {p.rden ? addr[15:0] : 16'h0, p.rden, d.rden, d.ssop, d.seop,
             d.rden ? d.idx : 3'd0, chip_of(n) == SopOfs, m_busy};
    act_v = {rom_addr_o, rom_rden_o, dat_vld_o, sym_sop_o, sym_eop_o,
             d.rden ? sym_idx_o : 3'd0, sop_o, busy_o};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle %0d outputs {addr,rden,vld,ssop,seop,idx,sop,busy}: got %h expected %h",
               n, act_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    n++;
    model_check();
  endtask

  task automatic run_scn(input scn_t s, input int id);
    int c_rden, c_vld, c_ssop, c_seop, c_busy, tail;
    c_rden = 0; c_vld = 0; c_ssop = 0; c_seop = 0; c_busy = 0; tail = 0;
    cfg_len_i        = 16'(s.len);
    cfg_sym_period_i = 3'(s.per);
    cfg_sym_mask_i   = s.mask;
    start_i          = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 400 && tail < 3; i++) begin
      c_rden += int'(rom_rden_o);
      c_vld  += int'(dat_vld_o);
      c_ssop += int'(sym_sop_o);
      c_seop += int'(sym_eop_o);
      if (busy_o && n >= run_cyc) c_busy++;
      if (n > run_cyc + s.stop_ofs && !busy_o) tail++;
      if (n == run_cyc + s.stop_ofs) stop_i = 1'b1;
      step();
      stop_i = 1'b0;
    end
    check($sformatf("scn%0d_rden_words", id), c_rden, s.e_rden);
    check($sformatf("scn%0d_vld_words", id), c_vld, s.e_rden);
    check($sformatf("scn%0d_sym_sop", id), c_ssop, s.e_ssop);
    check($sformatf("scn%0d_sym_eop", id), c_seop, s.e_seop);
    check($sformatf("scn%0d_busy_cycles", id), c_busy, s.e_busy);
  endtask

  initial begin
    scn_t scn [5];
    int   cnt, vcnt, found;

    scn[0] = '{4, 3, 8'h01, 13, 8, 2, 2, 16};
    scn[1] = '{1, 3, 8'h05,  5, 4, 4, 4,  6};
    scn[2] = '{3, 2, 8'h03,  0, 3, 1, 1,  3};
    scn[3] = '{2, 1, 8'h00,  3, 0, 0, 0,  4};
    scn[4] = '{5, 4, 8'h02,  7, 5, 1, 1, 10};

    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    cfg_len_i = '0; cfg_sym_period_i = '0; cfg_sym_mask_i = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    foreach (scn[i]) run_scn(scn[i], i);

    // Zero length is refused.
    cfg_len_i = 16'd0; cfg_sym_period_i = 3'd3; cfg_sym_mask_i = 8'h01;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    cnt = 0;
    repeat (3) begin step(); cnt += int'(busy_o); end
    check("illegal_len_busy", cnt, 0);

    // Stop in the same cycle as start wins.
    cfg_len_i = 16'd4;
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    cnt = 0;
    repeat (3) begin step(); cnt += int'(busy_o); end
    check("start_stop_busy", cnt, 0);

    // Start at chip 10: first read lands on the cycle after chip 95.
    for (int i = 0; i < 200 && chip_of(n) != 10; i++) step();
    cfg_len_i = 16'd4; cfg_sym_period_i = 3'd3; cfg_sym_mask_i = 8'h01;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    cnt = 1;
    while (!rom_rden_o && cnt < 200) begin step(); cnt++; end
    check("chip_align_latency", cnt, 86);

    // Reset while addr 2 is on the bus.
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (rom_rden_o && rom_addr_o == 16'd2) found = 1;
      else step();
    end
    check("rst_reach_addr2", found, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_outputs_clear",
          int'({rom_addr_o, rom_rden_o, dat_vld_o, sym_sop_o, sym_eop_o, sym_idx_o, sop_o, busy_o}),
          0);
    cnt = 0; vcnt = 0;
    while (!sop_o && cnt < 200) begin step(); cnt++; vcnt += int'(dat_vld_o); end
    check("rst_sop_resume", cnt, 3);
    check("rst_no_stale_vld", vcnt, 0);

    // Randomized traffic, including cfg churn while running.
    for (int i = 0; i < 6000; i++) begin
      cfg_len_i        = 16'($urandom_range(0, 6));
      cfg_sym_period_i = 3'($urandom_range(0, 7));
      cfg_sym_mask_i   = 8'($urandom);
      start_i          = ($urandom_range(0, 15) == 0);
      stop_i           = ($urandom_range(0, 60) == 0);
      rst              = ($urandom_range(0, 900) == 0);
      step();
    end
    start_i = 1'b0; stop_i = 1'b0; rst = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
